pp_axis2mat_frame_seq: RTL and testbench
========================================

// Module: pp_axis2mat_frame_seq
// PURPOSE
//  Frame sequencer for the AXI-stream-to-Mat dataflow region of pp_pipeline_accel.
//  Per frame: pushes rows/cols into the region's ap_fifo inputs, issues ap_start,
//  holds ap_continue, counts completions; repeats for N frames or until stopped.
//  Sits between the control-register block and the dataflow region; reports
//  busy/done/frame count/last-frame latency back to control.
// PARAMETERS
//  DIM_W  32  width of rows/cols values and FIFO data
//  CNT_W  16  width of frame count / frame counter
//  CYC_W  32  width of per-frame cycle counter (saturating)
// PORTS
//  ap_clk             in   1      clock
//  ap_rst_n           in   1      async reset, active low
//  cfg_start          in   1      pulse: begin run (sampled in IDLE only)
//  cfg_stop           in   1      pulse: stop after current frame
//  cfg_rows           in   DIM_W  frame rows (latched on accepted start)
//  cfg_cols           in   DIM_W  frame cols (latched on accepted start)
//  cfg_num_frames     in   CNT_W  frames to run; 0 = continuous until stop
//  busy               out  1      high in any state except IDLE
//  done               out  1      1-cycle pulse on run completion
//  err_cfg            out  1      1-cycle pulse: start rejected (rows or cols == 0)
//  frame_cnt          out  CNT_W  frames completed in current/last run
//  last_frame_cycles  out  CYC_W  cycles PUSH-entry -> ap_done of last frame
//  rows_din/rows_write  out DIM_W/1  rows FIFO write;  rows_full_n in 1
//  cols_din/cols_write  out DIM_W/1  cols FIFO write;  cols_full_n in 1
//  acc_ap_start       out  1      dataflow region ap_start
//  acc_ap_ready       in   1      dataflow region ap_ready
//  acc_ap_done        in   1      dataflow region ap_done
//  acc_ap_continue    out  1      dataflow region ap_continue
// BEHAVIOUR
//  Reset (async, ap_rst_n=0): state IDLE; all outputs 0; latched cfg, counters,
//   flags cleared. Deassertion synchronised internally; first active edge after.
//  States: IDLE -> PUSH -> START -> WAIT -> (PUSH | IDLE).
//  IDLE: cfg_start=1 with rows!=0 and cols!=0 -> latch cfg, frame_cnt<=0,
//   stop_pend<=0, -> PUSH next cycle. Zero dim -> err_cfg pulse next cycle, stay IDLE.
//   cfg_stop in IDLE ignored.
//  PUSH: rows_write=rows_full_n & ~rows_sent; cols_write likewise; independent,
//   may both fire same cycle; write takes effect when write&full_n. When both
//   sent -> START; sent flags cleared. Cycle counter reset to 0 on PUSH entry.
//  START: acc_ap_start=1 held until acc_ap_ready=1 (handshake cycle), then
//   acc_ap_start=0 next cycle -> WAIT. acc_ap_continue=1 in START and WAIT.
//  WAIT: acc_ap_done=1 -> frame_cnt+1, last_frame_cycles<=cycle counter.
//   acc_ap_done seen in START (same cycle as ready or earlier) is recorded in
//   done_seen and honoured; leave START/WAIT only when ready_seen & done_seen.
//  Frame end: if stop_pend or (num_frames!=0 and new frame_cnt==num_frames)
//   -> IDLE with done=1 one cycle; else -> PUSH (back-to-back, no idle cycle).
//  cfg_stop while busy sets stop_pend (sticky); takes effect at next frame end;
//   cfg_stop coincident with a frame's ap_done applies to that frame end.
//  cfg_start while busy ignored; cfg_* changes while busy do not affect run.
//  frame_cnt wraps at 2^CNT_W in continuous mode; cycle counter saturates at
//   all-ones. frame_cnt/last_frame_cycles hold after run until next start.
//  Outputs registered; latency cfg_start -> first rows_write = 1 cycle.
//  Reset mid-frame: immediate return to IDLE, strobes deassert; region reset
//   is the top level's responsibility.
// TESTING
//  rows=4,cols=8,num=1, FIFOs ready, ready 2 cyc after start, done 20 later
//   -> one write each (4,8), single start handshake, frame_cnt=1, done pulse.
//  num=3, cols_full_n low 5 cycles in frame 2 -> rows written at once, cols
//   delayed 5 cycles, 3 starts, frame_cnt=3, exactly one done.
//  num=0, cfg_stop during frame 4 -> frames 4 complete, no 5th start, done.
//  acc_ap_done and acc_ap_ready in same cycle -> frame counted once, next PUSH.
//  cfg_start with cols=0 -> err_cfg pulse, busy stays 0, no FIFO writes.
//  ap_rst_n low while acc_ap_start=1 -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/pp_axis2mat_frame_seq_if.sv
// ---------------------------------------------------------------------------
// pp_axis2mat_frame_seq_if
// Purpose : bundles the dataflow-region side of the frame sequencer: the two
//           ap_fifo write ports (rows, cols) and the ap_ctrl_chain handshake.
// Members : rows_din/rows_write/rows_full_n  rows FIFO write port
//           cols_din/cols_write/cols_full_n  cols FIFO write port
//           acc_ap_start/acc_ap_ready        start handshake
//           acc_ap_done/acc_ap_continue      completion handshake
// Modports: master = sequencer, slave = dataflow region.
// ---------------------------------------------------------------------------
interface pp_axis2mat_frame_seq_if #(
    parameter int DIM_W = 32
);
    logic [DIM_W-1:0] rows_din;
    logic             rows_write;
    logic             rows_full_n;
    logic [DIM_W-1:0] cols_din;
    logic             cols_write;
    logic             cols_full_n;
    logic             acc_ap_start;
    logic             acc_ap_ready;
    logic             acc_ap_done;
    logic             acc_ap_continue;

    modport master (
        output rows_din, rows_write, cols_din, cols_write,
        output acc_ap_start, acc_ap_continue,
        input  rows_full_n, cols_full_n, acc_ap_ready, acc_ap_done
    );

    modport slave (
        input  rows_din, rows_write, cols_din, cols_write,
        input  acc_ap_start, acc_ap_continue,
        output rows_full_n, cols_full_n, acc_ap_ready, acc_ap_done
    );
endinterface

// File: rtl/pp_axis2mat_frame_seq.sv
// ---------------------------------------------------------------------------
// pp_axis2mat_frame_seq
// Purpose : per-frame sequencer for the AXI-stream-to-Mat dataflow region.
//           Each frame pushes rows/cols into the region's FIFOs, performs the
//           ap_start/ap_ready handshake, holds ap_continue and waits for
//           ap_done. Repeats for cfg_num_frames frames (0 = until cfg_stop).
// Ports   : ap_clk, ap_rst_n        clock, async active-low reset
//           cfg_start/cfg_stop      run control pulses
//           cfg_rows/cfg_cols       frame geometry, latched on accepted start
//           cfg_num_frames          frames per run, 0 = continuous
//           busy/done/err_cfg       status (done, err_cfg are 1-cycle pulses)
//           frame_cnt               frames completed in current/last run
//           last_frame_cycles       PUSH entry -> ap_done of the last frame
//           fifo_acc                FIFO write ports + region handshake
// ---------------------------------------------------------------------------
module pp_axis2mat_frame_seq #(
    parameter int DIM_W = 32,
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [DIM_W-1:0]      cfg_rows,
    input  logic [DIM_W-1:0]      cfg_cols,
    input  logic [CNT_W-1:0]      cfg_num_frames,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CYC_W-1:0]      last_frame_cycles,
    pp_axis2mat_frame_seq_if.master fifo_acc
);

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_START, S_WAIT} state_t;

    localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [CNT_W-1:0] num_q, num_d, frame_cnt_q, frame_cnt_d;
    logic [CYC_W-1:0] cyc_q, cyc_d, last_cyc_q, last_cyc_d;
    logic             stop_pend_q, stop_pend_d;
    logic             done_seen_q, done_seen_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             rows_write_q, rows_write_d, cols_write_q, cols_write_d;
    logic             ap_start_q, ap_start_d, ap_continue_q, ap_continue_d;

    logic             rows_fire_s, cols_fire_s, frame_end_s, enter_push_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CYC_W-1:0] cyc_inc_s;

    // Reset synchroniser: assertion is immediate, release lands on a clock edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // The write strobes are registered, so a pending write stays asserted
    // until the FIFO accepts it; "sent" is simply the strobe having dropped.
    assign rows_fire_s = rows_write_q & fifo_acc.rows_full_n;
    assign cols_fire_s = cols_write_q & fifo_acc.cols_full_n;
    assign cyc_inc_s   = (&cyc_q) ? cyc_q : (cyc_q + CYC_ONE);
    assign cnt_next_s  = frame_cnt_q + CNT_ONE;

    // Next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        num_d         = num_q;
        frame_cnt_d   = frame_cnt_q;
        cyc_d         = cyc_q;
        last_cyc_d    = last_cyc_q;
        stop_pend_d   = stop_pend_q;
        done_seen_d   = done_seen_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        rows_write_d  = rows_write_q;
        cols_write_d  = cols_write_q;
        ap_start_d    = ap_start_q;
        ap_continue_d = ap_continue_q;
        frame_end_s   = 1'b0;
        enter_push_s  = 1'b0;

        // A stop while busy is sticky; it is also sampled directly at the
        // frame end so a stop coincident with ap_done ends that frame's run.
        if ((state_q != S_IDLE) && cfg_stop) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if ((cfg_rows != DIM_ZERO) && (cfg_cols != DIM_ZERO)) begin
                        rows_d       = cfg_rows;
                        cols_d       = cfg_cols;
                        num_d        = cfg_num_frames;
                        frame_cnt_d  = CNT_ZERO;
                        stop_pend_d  = 1'b0;
                        enter_push_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            S_PUSH: begin
                cyc_d        = cyc_inc_s;
                rows_write_d = rows_write_q & ~rows_fire_s;
                cols_write_d = cols_write_q & ~cols_fire_s;
                if (!rows_write_d && !cols_write_d) begin
                    state_d       = S_START;
                    ap_start_d    = 1'b1;
                    ap_continue_d = 1'b1;
                    done_seen_d   = 1'b0;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_START: begin
                cyc_d = cyc_inc_s;
                // ap_done may arrive before or with ap_ready; remember it.
                if (fifo_acc.acc_ap_done) begin
                    done_seen_d = 1'b1;
                    last_cyc_d  = cyc_q;
                end else begin
                    done_seen_d = done_seen_q;
                end
                if (fifo_acc.acc_ap_ready) begin
                    ap_start_d = 1'b0;
                    if (done_seen_q || fifo_acc.acc_ap_done) begin
                        frame_end_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    ap_start_d = 1'b1;
                end
            end
            S_WAIT: begin
                cyc_d = cyc_inc_s;
                if (fifo_acc.acc_ap_done) begin
                    last_cyc_d  = cyc_q;
                    frame_end_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_end_s) begin
            frame_cnt_d   = cnt_next_s;
            ap_continue_d = 1'b0;
            done_seen_d   = 1'b0;
            if (stop_pend_q || cfg_stop || ((num_q != CNT_ZERO) && (cnt_next_s == num_q))) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                enter_push_s = 1'b1;
            end
        end else begin
            frame_cnt_d = frame_cnt_d;
        end

        // Every PUSH entry re-arms both FIFO writes and restarts the frame timer.
        if (enter_push_s) begin
            state_d      = S_PUSH;
            rows_write_d = 1'b1;
            cols_write_d = 1'b1;
            cyc_d        = CYC_ZERO;
        end else begin
            cyc_d = cyc_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge ap_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= S_IDLE;
            rows_q        <= DIM_ZERO;
            cols_q        <= DIM_ZERO;
            num_q         <= CNT_ZERO;
            frame_cnt_q   <= CNT_ZERO;
            cyc_q         <= CYC_ZERO;
            last_cyc_q    <= CYC_ZERO;
            stop_pend_q   <= 1'b0;
            done_seen_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rows_write_q  <= 1'b0;
            cols_write_q  <= 1'b0;
            ap_start_q    <= 1'b0;
            ap_continue_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            num_q         <= num_d;
            frame_cnt_q   <= frame_cnt_d;
            cyc_q         <= cyc_d;
            last_cyc_q    <= last_cyc_d;
            stop_pend_q   <= stop_pend_d;
            done_seen_q   <= done_seen_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rows_write_q  <= rows_write_d;
            cols_write_q  <= cols_write_d;
            ap_start_q    <= ap_start_d;
            ap_continue_q <= ap_continue_d;
        end
    end

    assign busy                     = busy_q;
    assign done                     = done_q;
    assign err_cfg                  = err_q;
    assign frame_cnt                = frame_cnt_q;
    assign last_frame_cycles        = last_cyc_q;
    assign fifo_acc.rows_din        = rows_q;
    assign fifo_acc.rows_write      = rows_write_q;
    assign fifo_acc.cols_din        = cols_q;
    assign fifo_acc.cols_write      = cols_write_q;
    assign fifo_acc.acc_ap_start    = ap_start_q;
    assign fifo_acc.acc_ap_continue = ap_continue_q;

endmodule

// File: tb/tb_pp_axis2mat_frame_seq.sv
module tb_pp_axis2mat_frame_seq;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        cfg_start;
    logic        cfg_stop;
    logic [31:0] cfg_rows;
    logic [31:0] cfg_cols;
    logic [15:0] cfg_num_frames;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic [15:0] frame_cnt;
    logic [31:0] last_frame_cycles;

    pp_axis2mat_frame_seq_if #(.DIM_W(32)) bus ();

    pp_axis2mat_frame_seq #(.DIM_W(32), .CNT_W(16), .CYC_W(32)) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .cfg_rows          (cfg_rows),
        .cfg_cols          (cfg_cols),
        .cfg_num_frames    (cfg_num_frames),
        .busy              (busy),
        .done              (done),
        .err_cfg           (err_cfg),
        .frame_cnt         (frame_cnt),
        .last_frame_cycles (last_frame_cycles),
        .fifo_acc          (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_rows_wr = 0;
    int n_cols_wr = 0;
    int n_starts = 0;
    int n_done = 0;
    int n_errcfg = 0;

    logic [31:0] exp_rows[$];
    logic [31:0] exp_cols[$];
    logic [31:0] exp_done[$];

    // accelerator model knobs
    int rdy_dly = 2;
    int done_dly = 20;
    int m_age_s = 0;
    int m_age = 0;
    bit m_run = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dataflow-region model: ready rdy_dly cycles into ap_start, done done_dly after.
    always @(posedge ap_clk) begin
        #1;
        bus.acc_ap_ready = 1'b0;
        bus.acc_ap_done  = 1'b0;
        if (!ap_rst_n) begin
            m_run   = 1'b0;
            m_age   = 0;
            m_age_s = 0;
        end else if (m_run) begin
            m_age++;
            if (m_age == done_dly) begin
                bus.acc_ap_done = 1'b1;
                m_run = 1'b0;
            end
        end else if (bus.acc_ap_start) begin
            if (m_age_s == rdy_dly) begin
                bus.acc_ap_ready = 1'b1;
                m_age_s = 0;
                if (done_dly == 0) bus.acc_ap_done = 1'b1;
                else begin
                    m_run = 1'b1;
                    m_age = 0;
                end
            end else begin
                m_age_s++;
            end
        end
    end

    // Scoreboard side: pop expectations whenever the DUT produces an event.
    always @(negedge ap_clk) begin
        logic [31:0] e;
        if (ap_rst_n) begin
            if (bus.rows_write && bus.rows_full_n) begin
                n_rows_wr++;
                e = (exp_rows.size() != 0) ? exp_rows.pop_front() : 32'hxxxx_xxxx;
                check("rows_din", bus.rows_din, e);
            end
            if (bus.cols_write && bus.cols_full_n) begin
                n_cols_wr++;
                e = (exp_cols.size() != 0) ? exp_cols.pop_front() : 32'hxxxx_xxxx;
                check("cols_din", bus.cols_din, e);
            end
            if (bus.acc_ap_start && bus.acc_ap_ready) n_starts++;
            if (err_cfg) n_errcfg++;
            if (done) begin
                n_done++;
                e = (exp_done.size() != 0) ? exp_done.pop_front() : 32'hxxxx_xxxx;
                check("done_frame_cnt", frame_cnt, e);
            end
        end
    end

    task automatic push_run(input logic [31:0] r, input logic [31:0] c, input int nfr, input bit with_done);
        for (int i = 0; i < nfr; i++) begin
            exp_rows.push_back(r);
            exp_cols.push_back(c);
        end
        if (with_done) exp_done.push_back(nfr);
    endtask

    task automatic start_run(input logic [31:0] r, input logic [31:0] c, input logic [15:0] nfr);
        @(posedge ap_clk); #1;
        cfg_rows = r; cfg_cols = c; cfg_num_frames = nfr; cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) begin
            @(posedge ap_clk); #1;
        end
        check("done_count", n_done, target);
    endtask

    task automatic wait_frame_cnt(input logic [15:0] target, input int budget);
        for (int i = 0; i < budget && frame_cnt != target; i++) begin
            @(posedge ap_clk); #1;
        end
        check("wait_frame_cnt", frame_cnt, target);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        cfg_start = 1'b0; cfg_stop = 1'b0;
        cfg_rows = 32'd0; cfg_cols = 32'd0; cfg_num_frames = 16'd0;
        bus.rows_full_n = 1'b1; bus.cols_full_n = 1'b1;
        bus.acc_ap_ready = 1'b0; bus.acc_ap_done = 1'b0;

        // reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_start", bus.acc_ap_start, 1'b0);
        check("rst_rows_write", bus.rows_write, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        ap_rst_n = 1'b1;
        repeat (4) @(posedge ap_clk);

        // single frame: rows=4 cols=8, ready 2 cycles into start, done 20 later
        rdy_dly = 2; done_dly = 20;
        push_run(32'd4, 32'd8, 1, 1'b1);
        start_run(32'd4, 32'd8, 16'd1);
        check("t1_busy", busy, 1'b1);
        check("t1_write_latency", bus.rows_write, 1'b1);
        wait_done(1, 200);
        check("t1_frame_cnt", frame_cnt, 16'd1);
        check("t1_last_cycles", last_frame_cycles, 32'd23);
        check("t1_starts", n_starts, 1);
        check("t1_busy_after", busy, 1'b0);
        check("t1_done_pulse_width", done, 1'b0);

        // three frames, cols FIFO full for 5 cycles in frame 2, cfg changed while busy
        rdy_dly = 1; done_dly = 3;
        push_run(32'd10, 32'd20, 3, 1'b1);
        start_run(32'd10, 32'd20, 16'd3);
        cfg_rows = 32'd77; cfg_cols = 32'd88; cfg_num_frames = 16'd1;
        wait_frame_cnt(16'd1, 200);
        bus.cols_full_n = 1'b0;
        repeat (5) begin
            @(posedge ap_clk); #1;
        end
        check("t2_rows_at_once", n_rows_wr, 3);
        check("t2_cols_held", n_cols_wr, 2);
        check("t2_cols_pending", bus.cols_write, 1'b1);
        bus.cols_full_n = 1'b1;
        @(posedge ap_clk); #1;
        check("t2_cols_released", n_cols_wr, 3);
        wait_done(2, 300);
        repeat (5) @(posedge ap_clk);
        #1;
        check("t2_single_done", n_done, 2);
        check("t2_starts", n_starts, 4);
        check("t2_frame_cnt", frame_cnt, 16'd3);

        // continuous run, stop during frame 4, plus a start pulse that must be ignored
        rdy_dly = 1; done_dly = 2;
        push_run(32'd3, 32'd5, 4, 1'b1);
        start_run(32'd3, 32'd5, 16'd0);
        wait_frame_cnt(16'd3, 300);
        @(posedge ap_clk); #1;
        cfg_stop = 1'b1; cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_stop = 1'b0; cfg_start = 1'b0;
        wait_done(3, 200);
        repeat (10) @(posedge ap_clk);
        #1;
        check("t3_starts", n_starts, 8);
        check("t3_rows_writes", n_rows_wr, 8);
        check("t3_frame_cnt", frame_cnt, 16'd4);
        check("t3_busy", busy, 1'b0);

        // ready and done in the same cycle
        rdy_dly = 1; done_dly = 0;
        push_run(32'd1, 32'd2, 2, 1'b1);
        start_run(32'd1, 32'd2, 16'd2);
        wait_done(4, 200);
        check("t4_starts", n_starts, 10);
        check("t4_frame_cnt", frame_cnt, 16'd2);
        check("t4_last_cycles", last_frame_cycles, 32'd2);

        // zero cols rejected
        @(posedge ap_clk); #1;
        cfg_rows = 32'd4; cfg_cols = 32'd0; cfg_num_frames = 16'd1; cfg_start = 1'b1;
        @(posedge ap_clk); #1;
        cfg_start = 1'b0;
        check("t5_err_pulse", err_cfg, 1'b1);
        check("t5_busy", busy, 1'b0);
        @(posedge ap_clk); #1;
        check("t5_err_clear", err_cfg, 1'b0);
        repeat (3) @(posedge ap_clk);
        #1;
        check("t5_no_writes", n_rows_wr + n_cols_wr, 20);
        check("t5_err_count", n_errcfg, 1);
        check("t5_frame_cnt_held", frame_cnt, 16'd2);

        // reset while ap_start is asserted
        rdy_dly = 1000; done_dly = 1;
        push_run(32'd5, 32'd6, 1, 1'b0);
        start_run(32'd5, 32'd6, 16'd1);
        for (int i = 0; i < 50 && !bus.acc_ap_start; i++) begin
            @(posedge ap_clk); #1;
        end
        check("t6_start_seen", bus.acc_ap_start, 1'b1);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("t6_start_clear", bus.acc_ap_start, 1'b0);
        check("t6_continue_clear", bus.acc_ap_continue, 1'b0);
        check("t6_busy_clear", busy, 1'b0);
        check("t6_last_cycles_clear", last_frame_cycles, 32'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        repeat (6) @(posedge ap_clk);
        #1;
        check("t6_idle_busy", busy, 1'b0);
        check("t6_idle_start", bus.acc_ap_start, 1'b0);
        check("t6_rows_q_empty", exp_rows.size(), 0);
        check("t6_cols_q_empty", exp_cols.size(), 0);
        check("t6_done_q_empty", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
